// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between fetch and data requests.
// MEM_ARB_RR_EN: round-robin on ties; otherwise data has fixed priority.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic rr_last_i,
  output logic grant_d_o
);

  logic d_wins_tie;

`ifdef MEM_ARB_RR_EN
  // Data wins a tie only when fetch was the most recent grant.
  assign d_wins_tie = (rr_last_i == PORT_I);
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last_i;
  assign d_wins_tie     = 1'b1;
`endif

  assign grant_d_o = d_req_i & (~i_req_i | d_wins_tie);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data requests.
// MEM_ARB_RR_EN selects round-robin tie breaking in mem_arb_select.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_d;

  mem_arb_select u_select (
    .i_req_i   (i_req_i),
    .d_req_i   (d_req_i),
    .rr_last_i (rr_last_q),
    .grant_d_o (grant_d)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_i || d_req_i) begin
          owner_d   = grant_d ? PORT_D : PORT_I;
          rr_last_d = owner_d;
          if (grant_d) begin
            we_d    = d_we_i;
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_addr_i;
            wdata_d = '0;
          end
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_ack_i) begin
          // Stores capture read data too; the memory defines what it returns.
          if (owner_q == PORT_D) begin
            d_rdata_d = mem_rdata_i;
          end else begin
            i_rdata_d = mem_rdata_i;
          end
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      owner_q   <= PORT_I;
      rr_last_q <= PORT_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_req_o   = (state_q == StWait);
  assign busy_o      = (state_q != StIdle);
  assign i_ack_o     = (state_q == StResp) && (owner_q == PORT_I);
  assign d_ack_o     = (state_q == StResp) && (owner_q == PORT_D);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand-written corner sequences.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata_o, d_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          i_ack_o, d_ack_o, mem_req_o, mem_we_o, busy_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .i_req_i     (i_req),
    .i_addr_i    (i_addr),
    .i_rdata_o   (i_rdata_o),
    .i_ack_o     (i_ack_o),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_rdata_o   (d_rdata_o),
    .d_ack_o     (d_ack_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .busy_o      (busy_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          is_d;
    logic [DW-1:0] rdata;
  } sb_t;
  sb_t sb_q[$];
  logic [DW-1:0] last_i, last_d;

  typedef struct {
    logic          i_req;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    int            waits;
    logic [DW-1:0] rdata;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
  } vec_t;
  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_i_ack"}, 32'(i_ack_o), 32'd0);
    chk({tag, "_d_ack"}, 32'(d_ack_o), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata_o, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata_o, 32'd0);
  endtask

  // Called in the RESP cycle: pops the next expected acknowledge.
  task automatic check_resp(input string tag);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb_empty actual=0 required=1", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_i_ack"}, 32'(i_ack_o), 32'(!e.is_d));
    chk({tag, "_d_ack"}, 32'(d_ack_o), 32'(e.is_d));
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    chk({tag, "_mem_req_low"}, 32'(mem_req_o), 32'd0);
    if (e.is_d) begin
      chk({tag, "_d_rdata"}, d_rdata_o, e.rdata);
      chk({tag, "_i_rdata_hold"}, i_rdata_o, last_i);
      last_d = e.rdata;
    end else begin
      chk({tag, "_i_rdata"}, i_rdata_o, e.rdata);
      chk({tag, "_d_rdata_hold"}, d_rdata_o, last_d);
      last_i = e.rdata;
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (mem_req_o !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, 32'(mem_req_o), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst    = 1'b0;
    last_i = '0;
    last_d = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t       v;
    logic [3:0] tie_order;
    int         last_ack, acks;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 0, 32'h00A00093,
                1'b0, 32'h10, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'h12345678, 2, 32'hCAFEF00D,
                1'b1, 32'h40, 32'h12345678};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h55AA55AA, 1, 32'h11223344,
                1'b0, 32'h80, 32'h55AA55AA};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h14, 32'h99, 32'hFEEDFACE, 3, 32'h00B00113,
                1'b0, 32'h14, 32'h0};

    i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    do_reset();
    chk_all_zero("reset");

    for (int k = 0; k < 4; k++) begin
      v = vecs[k];
      i_req = v.i_req; d_req = v.d_req; d_we = v.d_we;
      i_addr = v.i_addr; d_addr = v.d_addr; d_wdata = v.d_wdata;
      sb_q.push_back('{v.d_req, v.rdata});
      chk($sformatf("v%0d_no_comb_req", k), 32'(mem_req_o), 32'd0);
      tick();
      chk($sformatf("v%0d_mem_req", k), 32'(mem_req_o), 32'd1);
      chk($sformatf("v%0d_busy", k), 32'(busy_o), 32'd1);
      for (int w = 0; w <= v.waits; w++) begin
        if (w > 0) tick();
        chk($sformatf("v%0d_w%0d_req", k, w), 32'(mem_req_o), 32'd1);
        chk($sformatf("v%0d_w%0d_we", k, w), 32'(mem_we_o), 32'(v.exp_we));
        chk($sformatf("v%0d_w%0d_addr", k, w), mem_addr_o, v.exp_addr);
        chk($sformatf("v%0d_w%0d_wdata", k, w), mem_wdata_o, v.exp_wdata);
      end
      mem_ack = 1'b1;
      mem_rdata = v.rdata;
      tick();
      mem_ack = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      i_req = 0;
      d_req = 0;
      check_resp($sformatf("v%0d", k));
      tick();
      chk($sformatf("v%0d_idle_i_ack", k), 32'(i_ack_o), 32'd0);
      chk($sformatf("v%0d_idle_d_ack", k), 32'(d_ack_o), 32'd0);
      chk($sformatf("v%0d_idle_busy", k), 32'(busy_o), 32'd0);
    end

    // Spurious memory acknowledge while idle.
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF0000;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("spur_busy", 32'(busy_o), 32'd0);
    chk("spur_mem_req", 32'(mem_req_o), 32'd0);
    chk("spur_i_ack", 32'(i_ack_o), 32'd0);
    chk("spur_d_ack", 32'(d_ack_o), 32'd0);
    chk("spur_mem_addr", mem_addr_o, 32'h14);
    chk("spur_i_rdata", i_rdata_o, 32'h00B00113);
    chk("spur_d_rdata", d_rdata_o, 32'h11223344);

    // Both ports requesting continuously.
`ifdef MEM_ARB_RR_EN
    tie_order = 4'b0101;
`else
    tie_order = 4'b1111;
`endif
    do_reset();
    i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0; d_wdata = 32'h0;
    i_req = 1'b1; d_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      sb_q.push_back('{tie_order[t], 32'h5000 + 32'(t)});
      wait_req($sformatf("tie%0d", t));
      chk($sformatf("tie%0d_addr", t), mem_addr_o, tie_order[t] ? 32'h200 : 32'h100);
      mem_ack = 1'b1;
      mem_rdata = 32'h5000 + 32'(t);
      tick();
      mem_ack = 1'b0;
      check_resp($sformatf("tie%0d", t));
      tick();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();

    // Back-to-back fetches against a zero-wait memory.
    i_req = 1'b1; i_addr = 32'h300; mem_rdata = 32'h00C0FFEE;
    last_ack = -1;
    acks = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      mem_ack = mem_req_o;
      tick();
      chk($sformatf("b2b_c%0d_d_ack", cyc), 32'(d_ack_o), 32'd0);
      if (i_ack_o) begin
        acks++;
        chk($sformatf("b2b_c%0d_busy", cyc), 32'(busy_o), 32'd1);
        chk($sformatf("b2b_c%0d_rdata", cyc), i_rdata_o, 32'h00C0FFEE);
        if (last_ack >= 0) chk($sformatf("b2b_c%0d_spacing", cyc), 32'(cyc - last_ack), 32'd3);
        last_ack = cyc;
      end
    end
    chk("b2b_ack_count", 32'(acks), 32'd5);
    i_req = 1'b0;
    mem_ack = 1'b0;
    tick();
    tick();

    // Reset while waiting on memory, with a late acknowledge.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    tick();
    chk("rstw_mem_req", 32'(mem_req_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d_req = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h77777777;
    chk_all_zero("rstw_a");
    tick();
    mem_ack = 1'b0;
    chk_all_zero("rstw_b");
    tick();
    chk_all_zero("rstw_c");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
